// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants for the FFT datapath: complex sample widths, default frame
// geometry and the input loader's state encoding.
// ---------------------------------------------------------------------------
package fft_pkg;

   // A complex sample is {real, imag}, each half of the full word.
   localparam int CMPLX_W = 64;
   localparam int HALF_W  = CMPLX_W / 2;

   // Default frame geometry; FFT_SIZE must equal 2**FFT_ADDR_W.
   localparam int FFT_SIZE   = 1024;
   localparam int FFT_ADDR_W = 10;

   // Loader states, kept as plain constants so older blocks can share them.
   localparam logic [1:0] LOAD  = 2'd0;
   localparam logic [1:0] FLUSH = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/fft_bitrev.sv
// ---------------------------------------------------------------------------
// fft_bitrev
// Purely combinational bit reversal of a RAM address. Shared by the input
// loader and the FFT core's address generator.
// Ports:
//   addr      in   addr_size  natural-order index
//   addr_rev  out  addr_size  index with bit order reversed
// ---------------------------------------------------------------------------
module fft_bitrev
   import fft_pkg::*;
#(
   parameter int addr_size = FFT_ADDR_W
) (
   input  logic [addr_size-1:0] addr,
   output logic [addr_size-1:0] addr_rev
);

   always_comb begin
      addr_rev = '0;
      for (int i = 0; i < addr_size; i++) begin
         addr_rev[i] = addr[addr_size-1-i];
      end
   end

endmodule

// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// fft_input_loader
// Streaming front end of the FFT. Accepts complex samples over valid/ready
// and writes them into port 0 of the sample RAM, optionally at bit-reversed
// addresses so the in-place radix-2 engine reads in butterfly order. Once a
// whole frame is resident it raises frame_ready and stalls input until the
// core returns the memory with a frame_ack pulse.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       complex sample {real, imag}
//   in_valid      sample valid
//   in_last       expected on the final sample of a frame (checked only)
//   in_ready      loader can take a sample this cycle
//   ram_wr_en     RAM port 0 write enable
//   ram_addr      RAM port 0 address
//   ram_data      RAM port 0 write data
//   frame_ready   a complete frame is resident in RAM
//   frame_ack     one-cycle pulse from the core releasing the memory
//   frame_err     sticky in_last mismatch flag, cleared by frame_ack
//   sample_cnt    samples accepted so far in the current frame
// ---------------------------------------------------------------------------
module fft_input_loader
   import fft_pkg::*;
#(
   parameter int width     = CMPLX_W,
   parameter int size      = FFT_SIZE,
   parameter int addr_size = FFT_ADDR_W,
   parameter int bitrev    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [width-1:0]     in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 ram_wr_en,
   output logic [addr_size-1:0] ram_addr,
   output logic [width-1:0]     ram_data,
   output logic                 frame_ready,
   input  logic                 frame_ack,
   output logic                 frame_err,
   output logic [addr_size-1:0] sample_cnt
);

   localparam logic [addr_size-1:0] LAST_IDX = addr_size'(size - 1);

   logic [1:0]           state;
   logic [addr_size-1:0] idx;
   logic [addr_size-1:0] idx_rev;
   logic [addr_size-1:0] wr_addr;
   logic                 accept;
   logic                 idx_last;

   fft_bitrev #(
      .addr_size (addr_size)
   ) u_bitrev (
      .addr     (idx),
      .addr_rev (idx_rev)
   );

   assign in_ready   = (state == LOAD);
   assign accept     = in_valid && in_ready;
   assign idx_last   = (idx == LAST_IDX);
   assign sample_cnt = idx;
   assign wr_addr    = (bitrev != 0) ? idx_rev : idx;

   // The write port is a one-stage register: an accepted sample shows up on
   // the RAM port the following cycle, and address/data hold when idle so
   // the RAM sees stable values between writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_wr_en <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         idx       <= '0;
      end else begin
         ram_wr_en <= accept;
         if (accept) begin
            ram_addr <= wr_addr;
            ram_data <= in_data;
            idx      <= idx_last ? '0 : idx + addr_size'(1);
         end
      end
   end

   // FLUSH exists so the final write is on the RAM port before frame_ready
   // rises; the core may start reading as soon as it sees frame_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= LOAD;
         frame_ready <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept && idx_last) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               state       <= FULL;
               frame_ready <= 1'b1;
            end
            FULL: begin
               if (frame_ack) begin
                  state       <= LOAD;
                  frame_ready <= 1'b0;
               end
            end
            default: begin
               state       <= LOAD;
               frame_ready <= 1'b0;
            end
         endcase
      end
   end

   // in_last only flags framing trouble; the frame length is fixed by size.
   // A fresh mismatch takes priority over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
      end else if (accept && (in_last != idx_last)) begin
         frame_err <= 1'b1;
      end else if (frame_ack) begin
         frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_input_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_input_loader
// Self-checking bench for fft_input_loader with size=8. Two instances share
// the stimulus: one bit-reversed, one natural order. A frame-level model
// (sample count, frame phase, expected write queue) predicts every output.
// ---------------------------------------------------------------------------
module tb_fft_input_loader;

   localparam int W      = 64;
   localparam int SIZE   = 8;
   localparam int ADDR_W = 3;

   localparam int PH_LOAD  = 0;
   localparam int PH_FLUSH = 1;
   localparam int PH_FULL  = 2;

   typedef struct {
      int          addr_rev;
      int          addr_nat;
      logic [W-1:0] data;
   } wr_t;

   logic              clk;
   logic              rst_n;
   logic [W-1:0]      in_data;
   logic              in_valid;
   logic              in_last;
   logic              frame_ack;

   logic              in_ready;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [W-1:0]      ram_data;
   logic              frame_ready;
   logic              frame_err;
   logic [ADDR_W-1:0] sample_cnt;

   logic              nat_in_ready;
   logic              nat_wr_en;
   logic [ADDR_W-1:0] nat_addr;
   logic [W-1:0]      nat_data;
   logic              nat_frame_ready;
   logic              nat_frame_err;
   logic [ADDR_W-1:0] nat_sample_cnt;

   int vec_cnt;
   int err_cnt;

   // Model state
   int           m_phase;
   int           m_count;
   logic         m_err;
   int           m_addr_rev;
   int           m_addr_nat;
   logic [W-1:0] m_data;
   wr_t          wr_q[$];

   fft_input_loader #(
      .width(W), .size(SIZE), .addr_size(ADDR_W), .bitrev(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .ram_wr_en(ram_wr_en),
      .ram_addr(ram_addr), .ram_data(ram_data), .frame_ready(frame_ready),
      .frame_ack(frame_ack), .frame_err(frame_err), .sample_cnt(sample_cnt)
   );

   fft_input_loader #(
      .width(W), .size(SIZE), .addr_size(ADDR_W), .bitrev(0)
   ) dut_nat (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(nat_in_ready), .ram_wr_en(nat_wr_en),
      .ram_addr(nat_addr), .ram_data(nat_data), .frame_ready(nat_frame_ready),
      .frame_ack(frame_ack), .frame_err(nat_frame_err), .sample_cnt(nat_sample_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reverse the low ADDR_W bits of v using plain arithmetic.
   function automatic int bitReverse(input int v);
      int r;
      int x;
      r = 0;
      x = v;
      for (int i = 0; i < ADDR_W; i++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_phase    = PH_LOAD;
      m_count    = 0;
      m_err      = 1'b0;
      m_addr_rev = 0;
      m_addr_nat = 0;
      m_data     = '0;
      wr_q.delete();
   endtask

   // Compare every output of both instances with the model.
   task automatic checkAll();
      wr_t w;
      if (wr_q.size() > 0) begin
         w = wr_q.pop_front();
         m_addr_rev = w.addr_rev;
         m_addr_nat = w.addr_nat;
         m_data     = w.data;
         checkOutput("wr_en", ram_wr_en, 1);
         checkOutput("nat_wr_en", nat_wr_en, 1);
      end else begin
         checkOutput("wr_en", ram_wr_en, 0);
         checkOutput("nat_wr_en", nat_wr_en, 0);
      end
      checkOutput("addr", ram_addr, m_addr_rev);
      checkOutput("data", ram_data, m_data);
      checkOutput("nat_addr", nat_addr, m_addr_nat);
      checkOutput("nat_data", nat_data, m_data);
      checkOutput("in_ready", in_ready, (m_phase == PH_LOAD));
      checkOutput("nat_in_ready", nat_in_ready, (m_phase == PH_LOAD));
      checkOutput("frame_ready", frame_ready, (m_phase == PH_FULL));
      checkOutput("frame_err", frame_err, m_err);
      checkOutput("sample_cnt", sample_cnt, m_count);
   endtask

   // Drive one cycle of inputs, advance the model at the clock edge, then
   // check the registered outputs just after the edge.
   task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic last, input logic ack);
      logic acc;
      bit   at_end;
      in_valid  = v;
      in_data   = d;
      in_last   = last;
      frame_ack = ack;
      @(posedge clk);
      acc    = v && (m_phase == PH_LOAD);
      at_end = (m_count == SIZE - 1);
      if (acc) begin
         wr_q.push_back('{addr_rev: bitReverse(m_count), addr_nat: m_count, data: d});
         if (last != at_end) m_err = 1'b1;
         else if (ack) m_err = 1'b0;
      end else if (ack) begin
         m_err = 1'b0;
      end
      if (m_phase == PH_FLUSH) m_phase = PH_FULL;
      else if (m_phase == PH_FULL && ack) m_phase = PH_LOAD;
      else if (acc && at_end) m_phase = PH_FLUSH;
      if (acc) m_count = (m_count + 1) % SIZE;
      #1;
      checkAll();
   endtask

   initial begin
      int   exp_tab[SIZE];
      int   written;
      logic v;
      logic a;
      logic l;

      vec_cnt   = 0;
      err_cnt   = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      frame_ack = 1'b0;
      exp_tab   = '{0, 4, 2, 6, 1, 5, 3, 7};
      modelReset();

      repeat (2) @(posedge clk);
      #1;
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] back-to-back frame");
      for (int k = 0; k < SIZE; k++) begin
         applyStimulus(1'b1, W'(k), (k == SIZE - 1), 1'b0);
         checkOutput("b2b_addr_tab", ram_addr, exp_tab[k]);
         checkOutput("b2b_nat_tab", nat_addr, k);
      end

      $display("[TB] backpressure in FULL");
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, W'(8), 1'b0, 1'b1);
      checkOutput("ack_drops_ready", frame_ready, 0);

      $display("[TB] bubbles");
      written = 0;
      for (int k = 8; k < 8 + SIZE; k++) begin
         applyStimulus(1'b1, W'(k), (k == 8 + SIZE - 1), 1'b0);
         checkOutput("bubble_addr_tab", ram_addr, exp_tab[k - 8]);
         applyStimulus(1'b0, '1, 1'b0, 1'b0);
         applyStimulus(1'b0, '1, 1'b0, 1'b0);
      end
      for (int c = 0; c < 2; c++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      $display("[TB] in_last mismatch");
      for (int k = 0; k < SIZE; k++) begin
         applyStimulus(1'b1, W'(100 + k), (k == 3), 1'b0);
      end
      checkOutput("err_sticky", frame_err, 1);
      for (int c = 0; c < 3; c++) applyStimulus(1'b1, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("err_cleared", frame_err, 0);

      $display("[TB] async reset mid-frame");
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, W'(200 + k), 1'b0, 1'b0);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      modelReset();
      #1;
      checkAll();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < SIZE; k++) begin
         applyStimulus(1'b1, W'(300 + k), (k == SIZE - 1), 1'b0);
         if (k == 0) checkOutput("post_reset_addr0", ram_addr, 0);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("post_reset_full", frame_ready, 1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 600; c++) begin
         v = ($urandom_range(0, 3) != 0);
         l = (m_count == SIZE - 1) ^ ($urandom_range(0, 15) == 0);
         if (m_phase == PH_FULL) a = ($urandom_range(0, 3) == 0);
         else if (!v) a = ($urandom_range(0, 15) == 0);
         else a = 1'b0;
         applyStimulus(v, {$urandom, $urandom}, l, a);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Streaming front end of the FFT: accepts complex time-domain samples over a valid/ready handshake and writes them into port 0 of the complex dual-port sample RAM.
- Writes use bit-reversed addresses, so the in-place radix-2 engine downstream reads in natural butterfly order.
- Signals a full frame to the FFT core and holds off new input until the core releases the memory.

Parameters:
- width, 64, complex sample width: {real[width/2-1:0], imag[width/2-1:0]}
- size, 1024, FFT points per frame; must equal 2**addr_size
- addr_size, 10, RAM address width
- bitrev, 1, 1 = bit-reversed write address; 0 = natural order (debug)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  width  complex sample {real, imag}
- in_valid  in  1  sample valid
- in_last  in  1  marks the final sample of a frame (checked only)
- in_ready  out  1  loader accepts a sample this cycle
- ram_wr_en  out  1  to RAM wr_en_0
- ram_addr  out  addr_size  to RAM addr_0
- ram_data  out  width  to RAM data_0_in
- frame_ready  out  1  level: a full frame is resident in RAM
- frame_ack  in  1  one-cycle pulse from the FFT core: memory released
- frame_err  out  1  sticky in_last mismatch flag
- sample_cnt  out  addr_size  samples accepted in the current frame

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=LOAD, idx=0, in_ready=1 combinationally from state, ram_wr_en=0, ram_addr=0, ram_data=0, frame_ready=0, frame_err=0, sample_cnt=0.
- States:
  - LOAD: in_ready=1.
  - FLUSH: one cycle, in_ready=0.
  - FULL: in_ready=0.
- Accept: in_valid && in_ready.
  - Next cycle, ram_wr_en=1 for exactly one cycle.
  - ram_data = in_data, registered.
  - ram_addr = bitrev ? reverse(idx over addr_size bits) : idx.
  - idx increments. Write latency is 1 cycle.
- No accept: ram_wr_en=0. ram_addr and ram_data hold their last values.
- Bubbles: in_valid low for any number of cycles is allowed. idx holds.
- LOAD->FLUSH: on the accept with idx==size-1. idx wraps to 0.
- FLUSH->FULL: unconditional after one cycle. The last write is presented during FLUSH. frame_ready rises on the FULL entry, i.e. the cycle after the last ram_wr_en.
- FULL->LOAD: on frame_ack. frame_ready falls that edge. in_ready=1 in the following cycle.
- frame_ack outside FULL: ignored, except that it clears frame_err.
- frame_err is set and sticky when either:
  - in_last=1 on an accept with idx!=size-1, or
  - in_last=0 on the accept with idx==size-1.
- frame_err is cleared only by frame_ack or reset.
- A mismatch never shortens or extends the frame; the frame always closes at size accepts.
- sample_cnt = idx, registered. It reads 0 in FLUSH and FULL after wrap.
- Reset mid-frame: idx=0, any partial frame is discarded, no write is issued after reset.
- Loader never drives RAM port 1. Port 1 belongs to the FFT core.
- Throughput: one sample per cycle in LOAD. Per-frame overhead is FLUSH (1 cycle) plus the time in FULL.

Decomposition:
- fft_pkg holds:
  - cmplx width constants (CMPLX_W=64, HALF_W=32)
  - FFT_SIZE / FFT_ADDR_W defaults
  - state encoding localparams (LOAD, FLUSH, FULL)
- Sub-module fft_bitrev: combinational, parameterised by addr_size; out[i]=in[addr_size-1-i]. The FFT core's address generator reuses it.

Test Plan:
- Bench config: size=8, addr_size=3.
- Back-to-back frame: in_valid held high, in_data=k for k=0..7, in_last on k=7 -> writes at ram_addr 0,4,2,6,1,5,3,7 carrying data 0..7. frame_ready=1 one cycle after the last write. in_ready=0 afterwards. frame_err=0.
- Bubbles: in_valid toggles 1,0,0,1,... -> exactly 8 ram_wr_en pulses with identical addr/data sequence. No write on idle cycles. sample_cnt steps 0..7.
- Backpressure: in_valid held high in FULL for 5 cycles, then frame_ack -> no writes and in_ready=0 during FULL. frame_ready falls on ack. The next sample (k=8) is written at addr 0 two cycles after ack.
- Last mismatch: in_last on k=3, none on k=7 -> frame_err=1 from the cycle after k=3. Frame still closes after 8 samples. frame_ack clears frame_err.
- Async reset mid-frame: rst_n low after 3 accepts, asserted between clock edges -> outputs reset immediately. After release the first write goes to addr 0 and a full 8-sample frame is required before frame_ready.
- bitrev=0: a frame of 0..7 -> addresses 0..7 in natural order.
